// File: rtl/handshake_channel_monitor.sv
// ---------------------------------------------------------------------------
// handshake_channel_monitor
//
// Passive protocol monitor for NUM_CHANNELS ready/valid channels. Each
// channel runs a small IDLE/STALL state machine. It checks three rules:
//   - valid must stay high until the transfer is accepted (err_drop)
//   - data must stay stable while the channel is stalled (err_data)
//   - a stall must not last TIMEOUT cycles (err_timeout)
// The monitor also counts completed transfers per channel. Error flags are
// sticky, and the channel index of the first error is latched. The monitor
// only observes its inputs and never drives the design it is bound to.
//
// Ports
//   CLK           monitor clock, rising edge
//   RESET         synchronous active-high reset, overrides everything
//   enable        1 = checking active, 0 = freeze all state
//   clear_counts  zeroes the transfer and stall counters; errors are kept
//   valid/ready   per-channel handshake bits
//   data          payload, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   xfer_count    saturating transfer counters, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   err_drop      sticky, valid fell while stalled
//   err_data      sticky, data changed while stalled
//   err_timeout   sticky, stall reached TIMEOUT cycles
//   err_any       OR of every sticky error bit
//   err_first_ch  channel that raised the first error (lowest index on a tie)
//   err_first_vld err_first_ch holds a valid index
// ---------------------------------------------------------------------------
module handshake_channel_monitor #(
  parameter int NUM_CHANNELS = 3,
  parameter int DATA_WIDTH   = 5,
  parameter int TIMEOUT      = 16,
  parameter int CNT_WIDTH    = 16,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               enable,
  input  logic                               clear_counts,
  input  logic [NUM_CHANNELS-1:0]            valid,
  input  logic [NUM_CHANNELS-1:0]            ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0]  xfer_count,
  output logic [NUM_CHANNELS-1:0]            err_drop,
  output logic [NUM_CHANNELS-1:0]            err_data,
  output logic [NUM_CHANNELS-1:0]            err_timeout,
  output logic                               err_any,
  output logic [CH_W-1:0]                    err_first_ch,
  output logic                               err_first_vld
);

  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [0:0]              r_state    [NUM_CHANNELS];
  logic [STALL_W-1:0]      r_stallCnt [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   r_capData  [NUM_CHANNELS];
  logic [0:0]              w_nextState[NUM_CHANNELS];
  logic [STALL_W-1:0]      w_nextStall[NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   w_nextCap  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   w_chData   [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] w_xfer;
  logic [NUM_CHANNELS-1:0] w_setDrop;
  logic [NUM_CHANNELS-1:0] w_setData;
  logic [NUM_CHANNELS-1:0] w_setTimeout;
  logic [NUM_CHANNELS-1:0] w_newErr;
  logic [CH_W-1:0]         w_firstIdx;

  logic [NUM_CHANNELS*CNT_WIDTH-1:0] r_xferCount;
  logic [NUM_CHANNELS-1:0]           r_errDrop;
  logic [NUM_CHANNELS-1:0]           r_errData;
  logic [NUM_CHANNELS-1:0]           r_errTimeout;
  logic                              r_errAny;
  logic [CH_W-1:0]                   r_firstCh;
  logic                              r_firstVld;

  // Next-state logic for every channel. Nothing moves while enable is low.
  // The stall counter stops at TIMEOUT, so the timeout event can occur only
  // once per stall. The captured data is never refreshed mid-stall, so
  // every stalled cycle is compared against the value seen on stall entry.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_chData[i]     = data[i*DATA_WIDTH +: DATA_WIDTH];
      w_nextState[i]  = r_state[i];
      w_nextStall[i]  = r_stallCnt[i];
      w_nextCap[i]    = r_capData[i];
      w_xfer[i]       = 1'b0;
      w_setDrop[i]    = 1'b0;
      w_setData[i]    = 1'b0;
      w_setTimeout[i] = 1'b0;
      if (enable) begin
        if (r_state[i] == ST_IDLE) begin
          if (valid[i] && ready[i]) begin
            w_xfer[i] = 1'b1;
          end else if (valid[i]) begin
            w_nextState[i] = ST_STALL;
            w_nextCap[i]   = w_chData[i];
            w_nextStall[i] = STALL_W'(1);
          end
        end else begin
          if (valid[i]) begin
            if (w_chData[i] != r_capData[i]) begin
              w_setData[i] = 1'b1;
            end
            if (ready[i]) begin
              w_xfer[i]      = 1'b1;
              w_nextState[i] = ST_IDLE;
              w_nextStall[i] = '0;
            end else if (r_stallCnt[i] < STALL_W'(TIMEOUT)) begin
              w_nextStall[i] = r_stallCnt[i] + 1'b1;
              if (r_stallCnt[i] == STALL_W'(TIMEOUT - 1)) begin
                w_setTimeout[i] = 1'b1;
              end
            end
          end else begin
            w_setDrop[i]   = 1'b1;
            w_nextState[i] = ST_IDLE;
            w_nextStall[i] = '0;
          end
        end
        if (clear_counts) begin
          w_nextStall[i] = '0;
        end
      end
    end
  end

  // Which channel raises an error on this edge. The loop runs downward, so
  // the lowest index is assigned last and wins a same-edge tie.
  always_comb begin
    w_newErr   = w_setDrop | w_setData | w_setTimeout;
    w_firstIdx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (w_newErr[i]) begin
        w_firstIdx = CH_W'(i);
      end
    end
  end

  // Per-channel state registers and saturating transfer counters. A clear
  // takes priority over a transfer on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_xferCount <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_state[i]    <= ST_IDLE;
        r_stallCnt[i] <= '0;
        r_capData[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_state[i]    <= w_nextState[i];
        r_stallCnt[i] <= w_nextStall[i];
        r_capData[i]  <= w_nextCap[i];
        if (enable && clear_counts) begin
          r_xferCount[i*CNT_WIDTH +: CNT_WIDTH] <= '0;
        end else if (w_xfer[i] && (r_xferCount[i*CNT_WIDTH +: CNT_WIDTH] != CNT_MAX)) begin
          r_xferCount[i*CNT_WIDTH +: CNT_WIDTH] <= r_xferCount[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
        end
      end
    end
  end

  // Sticky error flags. err_any is built from the next flag values so it
  // changes on the same edge as the flags. The first-offender record is
  // written only once after reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_errDrop    <= '0;
      r_errData    <= '0;
      r_errTimeout <= '0;
      r_errAny     <= 1'b0;
      r_firstCh    <= '0;
      r_firstVld   <= 1'b0;
    end else begin
      r_errDrop    <= r_errDrop | w_setDrop;
      r_errData    <= r_errData | w_setData;
      r_errTimeout <= r_errTimeout | w_setTimeout;
      r_errAny     <= |{r_errDrop, r_errData, r_errTimeout, w_newErr};
      if (!r_firstVld && (|w_newErr)) begin
        r_firstCh  <= w_firstIdx;
        r_firstVld <= 1'b1;
      end
    end
  end

  assign xfer_count    = r_xferCount;
  assign err_drop      = r_errDrop;
  assign err_data      = r_errData;
  assign err_timeout   = r_errTimeout;
  assign err_any       = r_errAny;
  assign err_first_ch  = r_firstCh;
  assign err_first_vld = r_firstVld;

endmodule

// File: tb/tb_handshake_channel_monitor.sv
// ---------------------------------------------------------------------------
// tb_handshake_channel_monitor
//
// Directed bench for handshake_channel_monitor. The main instance uses the
// default parameters. A second instance with one channel, an 8-bit counter
// and TIMEOUT=2 covers counter saturation and the shortest legal timeout in
// a few hundred cycles. Inputs change on the falling edge, and outputs are
// sampled on the falling edge that follows each rising edge.
// ---------------------------------------------------------------------------
module tb_handshake_channel_monitor;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        enable;
  logic        clearCounts;
  logic [2:0]  valid;
  logic [2:0]  ready;
  logic [14:0] data;
  logic [47:0] xferCount;
  logic [2:0]  errDrop;
  logic [2:0]  errData;
  logic [2:0]  errTimeout;
  logic        errAny;
  logic [1:0]  errFirstCh;
  logic        errFirstVld;

  logic        sClear;
  logic [0:0]  sValid;
  logic [0:0]  sReady;
  logic [4:0]  sData;
  logic [7:0]  sXferCount;
  logic [0:0]  sErrDrop;
  logic [0:0]  sErrData;
  logic [0:0]  sErrTimeout;
  logic        sErrAny;
  logic [0:0]  sErrFirstCh;
  logic        sErrFirstVld;

  int checks   = 0;
  int failures = 0;

  handshake_channel_monitor #(
    .NUM_CHANNELS(3), .DATA_WIDTH(5), .TIMEOUT(16), .CNT_WIDTH(16)
  ) dut (
    .CLK(CLK), .RESET(RESET), .enable(enable), .clear_counts(clearCounts),
    .valid(valid), .ready(ready), .data(data),
    .xfer_count(xferCount), .err_drop(errDrop), .err_data(errData),
    .err_timeout(errTimeout), .err_any(errAny),
    .err_first_ch(errFirstCh), .err_first_vld(errFirstVld)
  );

  handshake_channel_monitor #(
    .NUM_CHANNELS(1), .DATA_WIDTH(5), .TIMEOUT(2), .CNT_WIDTH(8)
  ) dutSmall (
    .CLK(CLK), .RESET(RESET), .enable(enable), .clear_counts(sClear),
    .valid(sValid), .ready(sReady), .data(sData),
    .xfer_count(sXferCount), .err_drop(sErrDrop), .err_data(sErrData),
    .err_timeout(sErrTimeout), .err_any(sErrAny),
    .err_first_ch(sErrFirstCh), .err_first_vld(sErrFirstVld)
  );

  // 10 time-unit clock
  always #5 CLK = ~CLK;

  // Safety net in case the sequence stops advancing
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance n rising edges, returning at the following falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1; enable = 1'b1; clearCounts = 1'b0;
    valid = '0; ready = '0; data = '0;
    sClear = 1'b0; sValid = '0; sReady = '0; sData = '0;
    tick(2);
    RESET = 1'b0;
    tick(1);
    checks++;
    if (xferCount !== 48'h0) begin failures++; $display("[TB] FAIL reset_count: got %h expected 0", xferCount); end
    checks++;
    if ({errDrop, errData, errTimeout, errAny, errFirstVld} !== 11'h0) begin
      failures++; $display("[TB] FAIL reset_errors: got %b expected 0", {errDrop, errData, errTimeout, errAny, errFirstVld});
    end
  endtask

  task automatic test_back_to_back();
    valid = 3'b001; ready = 3'b001;
    tick(4);
    valid = '0; ready = '0;
    checks++;
    if (xferCount[15:0] !== 16'd4) begin failures++; $display("[TB] FAIL b2b_count0: got %0d expected 4", xferCount[15:0]); end
    checks++;
    if (errAny !== 1'b0) begin failures++; $display("[TB] FAIL b2b_err_any: got %b expected 0", errAny); end
  endtask

  task automatic test_clean_stall();
    data[9:5] = 5'h0A; valid = 3'b010; ready = 3'b000;
    tick(3);
    ready = 3'b010;
    tick(1);
    valid = '0; ready = '0;
    checks++;
    if (xferCount[31:16] !== 16'd1) begin failures++; $display("[TB] FAIL stall_count1: got %0d expected 1", xferCount[31:16]); end
    checks++;
    if (errAny !== 1'b0) begin failures++; $display("[TB] FAIL stall_err_any: got %b expected 0", errAny); end
  endtask

  task automatic test_data_error();
    data[14:10] = 5'h03; valid = 3'b100; ready = 3'b000;
    tick(1);
    checks++;
    if (errData !== 3'b000) begin failures++; $display("[TB] FAIL data_before: got %b expected 000", errData); end
    data[14:10] = 5'h04;
    tick(1);
    checks++;
    if (errData !== 3'b100) begin failures++; $display("[TB] FAIL data_err: got %b expected 100", errData); end
    checks++;
    if ({errFirstVld, errFirstCh} !== 3'b110) begin
      failures++; $display("[TB] FAIL data_first: got vld=%b ch=%0d expected vld=1 ch=2", errFirstVld, errFirstCh);
    end
    checks++;
    if (errAny !== 1'b1) begin failures++; $display("[TB] FAIL data_err_any: got %b expected 1", errAny); end
    ready = 3'b100;
    tick(1);
    valid = '0; ready = '0;
    checks++;
    if (xferCount[47:32] !== 16'd1) begin failures++; $display("[TB] FAIL data_count2: got %0d expected 1", xferCount[47:32]); end
  endtask

  task automatic test_timeout();
    valid = 3'b001; ready = 3'b000;
    tick(15);
    checks++;
    if (errTimeout !== 3'b000) begin failures++; $display("[TB] FAIL timeout_early: got %b expected 000", errTimeout); end
    tick(1);
    checks++;
    if (errTimeout !== 3'b001) begin failures++; $display("[TB] FAIL timeout_set: got %b expected 001", errTimeout); end
    tick(5);
    ready = 3'b001;
    tick(1);
    valid = '0; ready = '0;
    checks++;
    if (errFirstCh !== 2'd2) begin failures++; $display("[TB] FAIL timeout_first_kept: got %0d expected 2", errFirstCh); end
    checks++;
    if (xferCount[15:0] !== 16'd5) begin failures++; $display("[TB] FAIL timeout_count0: got %0d expected 5", xferCount[15:0]); end
  endtask

  task automatic test_tie_and_clear();
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    valid = 3'b100; ready = 3'b100;
    tick(2);
    data[9:5] = 5'h01; valid = 3'b011; ready = 3'b000;
    tick(1);
    data[9:5] = 5'h02; valid = 3'b010;
    tick(1);
    checks++;
    if ({errDrop, errData} !== 6'b001_010) begin
      failures++; $display("[TB] FAIL tie_flags: got drop=%b data=%b expected drop=001 data=010", errDrop, errData);
    end
    checks++;
    if ({errFirstVld, errFirstCh} !== 3'b100) begin
      failures++; $display("[TB] FAIL tie_first: got vld=%b ch=%0d expected vld=1 ch=0", errFirstVld, errFirstCh);
    end
    clearCounts = 1'b1; valid = 3'b110; ready = 3'b100;
    tick(1);
    checks++;
    if (xferCount !== 48'h0) begin failures++; $display("[TB] FAIL clear_counts: got %h expected 0", xferCount); end
    checks++;
    if ({errDrop, errData} !== 6'b001_010) begin
      failures++; $display("[TB] FAIL clear_keeps_flags: got drop=%b data=%b expected drop=001 data=010", errDrop, errData);
    end
    clearCounts = 1'b0; valid = '0; ready = '0;
    tick(1);
    checks++;
    if (errDrop !== 3'b011) begin failures++; $display("[TB] FAIL clear_stall_kept: got %b expected 011", errDrop); end
  endtask

  task automatic test_enable();
    enable = 1'b0; valid = 3'b001; ready = 3'b001;
    tick(2);
    checks++;
    if (xferCount[15:0] !== 16'd0) begin failures++; $display("[TB] FAIL disabled_count: got %0d expected 0", xferCount[15:0]); end
    enable = 1'b1;
    tick(1);
    valid = '0; ready = '0;
    checks++;
    if (xferCount[15:0] !== 16'd1) begin failures++; $display("[TB] FAIL reenabled_count: got %0d expected 1", xferCount[15:0]); end
  endtask

  task automatic test_reset_mid_stall();
    valid = 3'b001; ready = 3'b000;
    tick(3);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0; valid = '0;
    tick(1);
    valid = 3'b001; ready = 3'b001;
    tick(1);
    valid = '0; ready = '0;
    tick(1);
    checks++;
    if ({errDrop, errData, errTimeout, errAny, errFirstVld} !== 11'h0) begin
      failures++; $display("[TB] FAIL midstall_errors: got %b expected 0", {errDrop, errData, errTimeout, errAny, errFirstVld});
    end
    checks++;
    if (xferCount !== 48'h1) begin failures++; $display("[TB] FAIL midstall_count: got %h expected 1", xferCount); end
  endtask

  task automatic test_saturation();
    sValid = 1'b1; sReady = 1'b1;
    tick(255);
    checks++;
    if (sXferCount !== 8'hFF) begin failures++; $display("[TB] FAIL sat_reach: got %h expected ff", sXferCount); end
    tick(1);
    checks++;
    if (sXferCount !== 8'hFF) begin failures++; $display("[TB] FAIL sat_hold: got %h expected ff", sXferCount); end
    sReady = 1'b0;
    tick(1);
    checks++;
    if (sErrTimeout !== 1'b0) begin failures++; $display("[TB] FAIL small_timeout_early: got %b expected 0", sErrTimeout); end
    tick(1);
    checks++;
    if ({sErrTimeout, sErrAny, sErrFirstVld} !== 3'b111) begin
      failures++; $display("[TB] FAIL small_timeout_set: got %b expected 111", {sErrTimeout, sErrAny, sErrFirstVld});
    end
    sValid = 1'b0;
  endtask

  initial begin
    $display("[TB] starting handshake_channel_monitor bench");
    test_reset();
    test_back_to_back();
    test_clean_stall();
    test_data_error();
    test_timeout();
    test_tie_and_clear();
    test_enable();
    test_reset_mid_stall();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
